// File: rtl/el2_ahb_pkg.sv
// ---------------------------------------------------------------------------
// el2_ahb_pkg
// Shared AHB-Lite encodings and the responder state type used by the
// on-chip SRAM slave and its byte-lane decoder.
//   - HTRANS codes : IDLE / BUSY / NONSEQ / SEQ
//   - HSIZE codes  : BYTE / HALF / WORD / DWORD (values above DWORD illegal)
//   - HRESP codes  : OKAY / ERROR
//   - ahb_state_e  : responder data-phase state
// ---------------------------------------------------------------------------
package el2_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RDATA  = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } ahb_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ---------------------------------------------------------------------------
// ahb_byte_lane_decode
// Combinational decode of transfer size and low address bits into the
// eight byte-lane enables of a 64-bit data bus, plus a misalignment flag.
// Ports:
//   size     in  3  HSIZE code
//   addr_lo  in  3  HADDR[2:0]
//   be       out 8  byte enables, bit i = byte lane i
//   misalign out 1  address not naturally aligned for the size
// Illegal sizes produce no lanes; the caller flags them separately.
// ---------------------------------------------------------------------------
module ahb_byte_lane_decode
   import el2_ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [2:0] addr_lo,
   output logic [7:0] be,
   output logic       misalign
);

   // Lane mask is the size-wide mask shifted to the aligned lane offset.
   always_comb begin
      be       = 8'h00;
      misalign = 1'b0;
      case (size)
         HSIZE_BYTE: begin
            be       = 8'h01 << addr_lo;
            misalign = 1'b0;
         end
         HSIZE_HALF: begin
            be       = 8'h03 << {addr_lo[2:1], 1'b0};
            misalign = addr_lo[0];
         end
         HSIZE_WORD: begin
            be       = 8'h0F << {addr_lo[2], 2'b00};
            misalign = |addr_lo[1:0];
         end
         HSIZE_DWORD: begin
            be       = 8'hFF;
            misalign = |addr_lo;
         end
         default: begin
            be       = 8'h00;
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite responder in front of a single-port synchronous SRAM with
// 1-cycle read latency. Supports byte/half/word/dword transfers, a
// programmable number of leading wait states and a two-cycle ERROR response.
// Ports:
//   HCLK, HRESET (sync, active-high)
//   HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HREADY  address phase
//   HWDATA[63:0]                                                data phase
//   HREADYOUT, HRESP, HRDATA[63:0]                              responses
//   mem_en, mem_we, mem_be[7:0], mem_addr, mem_wdata[63:0]      SRAM request
//   mem_rdata[63:0]                                             SRAM read data
// New address phases are accepted in IDLE and in every completion cycle
// (ACCESS-write, RDATA, ERR2), which gives gap-free back-to-back transfers.
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave
   import el2_ahb_pkg::*;
#(
   parameter int DEPTH_LOG2  = 13,
   parameter int WAIT_STATES = 0
)(
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [63:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [63:0]           HRDATA,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [7:0]            mem_be,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [63:0]           mem_wdata,
   input  logic [63:0]           mem_rdata
);

   // Final wait-counter value before moving on to the SRAM access.
   localparam logic [2:0] WS_LAST = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   ahb_state_e            state_r;
   ahb_state_e            state_nxt_s;
   logic [2:0]            wcnt_r;
   logic [2:0]            wcnt_nxt_s;
   logic [DEPTH_LOG2-1:0] addr_r;
   logic                  we_r;
   logic [7:0]            be_r;

   logic                  sample_s;
   logic                  completion_s;
   logic                  accept_s;
   logic [7:0]            lane_be_s;
   logic                  misalign_s;
   logic                  range_err_s;
   logic                  size_err_s;
   logic                  err_s;
   logic                  unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   ahb_byte_lane_decode u_lane (
      .size     (HSIZE),
      .addr_lo  (HADDR[2:0]),
      .be       (lane_be_s),
      .misalign (misalign_s)
   );

   assign sample_s    = HSEL & HREADY & HTRANS[1];
   // Any address bit above the SRAM window is an out-of-range access.
   assign range_err_s = (HADDR >> (DEPTH_LOG2 + 3)) != 32'd0;
   assign size_err_s  = HSIZE > HSIZE_DWORD;
   assign err_s       = size_err_s | misalign_s | range_err_s;
   assign accept_s    = completion_s & sample_s;

   // Cycles in which a new address phase may be taken.
   always_comb begin
      completion_s = 1'b0;
      case (state_r)
         ST_IDLE:   completion_s = 1'b1;
         ST_ACCESS: completion_s = we_r;
         ST_RDATA:  completion_s = 1'b1;
         ST_ERR2:   completion_s = 1'b1;
         default:   completion_s = 1'b0;
      endcase
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      wcnt_nxt_s  = wcnt_r;
      if (completion_s) begin
         wcnt_nxt_s = 3'd0;
         if (!sample_s) begin
            state_nxt_s = ST_IDLE;
         end else if (err_s) begin
            state_nxt_s = ST_ERR1;
         end else if (WAIT_STATES > 0) begin
            state_nxt_s = ST_WAIT;
         end else begin
            state_nxt_s = ST_ACCESS;
         end
      end else begin
         case (state_r)
            ST_WAIT: begin
               if (wcnt_r == WS_LAST) begin
                  state_nxt_s = ST_ACCESS;
                  wcnt_nxt_s  = 3'd0;
               end else begin
                  wcnt_nxt_s  = wcnt_r + 3'd1;
               end
            end
            // Only a read reaches here: a write ACCESS is a completion cycle.
            ST_ACCESS: state_nxt_s = ST_RDATA;
            ST_ERR1:   state_nxt_s = ST_ERR2;
            default:   state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State, counter and latched address-phase registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 3'd0;
         addr_r  <= '0;
         we_r    <= 1'b0;
         be_r    <= 8'h00;
      end else begin
         state_r <= state_nxt_s;
         wcnt_r  <= wcnt_nxt_s;
         if (accept_s) begin
            addr_r <= HADDR[DEPTH_LOG2+2:3];
            we_r   <= HWRITE;
            be_r   <= lane_be_s;
         end else begin
            addr_r <= addr_r;
            we_r   <= we_r;
            be_r   <= be_r;
         end
      end
   end

   // Bus responses and SRAM strobes decoded from the current state.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = 64'h0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 8'h00;
      case (state_r)
         ST_IDLE: begin
            HREADYOUT = 1'b1;
         end
         ST_WAIT: begin
            HREADYOUT = 1'b0;
         end
         ST_ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_r;
            mem_be    = be_r;
            // Reads need one more cycle for the SRAM to return data.
            HREADYOUT = we_r;
         end
         ST_RDATA: begin
            HRDATA    = mem_rdata;
            HREADYOUT = 1'b1;
         end
         ST_ERR1: begin
            HRESP     = HRESP_ERROR;
            HREADYOUT = 1'b0;
         end
         ST_ERR2: begin
            HRESP     = HRESP_ERROR;
            HREADYOUT = 1'b1;
         end
         default: begin
            HREADYOUT = 1'b1;
         end
      endcase
   end

   assign mem_addr  = addr_r;
   assign mem_wdata = HWDATA;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
// Directed bench for two responder instances sharing one bus: u0 with no
// wait states (HREADY driven by the bench) and u3 with three wait states
// (HREADY tied to its own HREADYOUT). Each instance has a behavioural SRAM.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;
   import el2_ahb_pkg::*;

   logic        clk = 1'b0;
   logic        hreset;
   logic        hsel0, hsel3;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [63:0] hwdata;
   logic        hready0;

   logic        hro0, hresp0, en0, we0;
   logic [63:0] hrdata0, wdata0;
   logic [63:0] rdata0 = 64'h0;
   logic [7:0]  be0;
   logic [12:0] addr0;

   logic        hro3, hresp3, en3, we3;
   logic [63:0] hrdata3, wdata3;
   logic [63:0] rdata3 = 64'h0;
   logic [7:0]  be3;
   logic [12:0] addr3;

   logic [63:0] mem0 [0:8191];
   logic [63:0] mem3 [0:8191];
   int          wr_cnt3 = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ahb_lite_sram_slave #(.DEPTH_LOG2(13), .WAIT_STATES(0)) u0 (
      .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
      .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0),
      .mem_en(en0), .mem_we(we0), .mem_be(be0), .mem_addr(addr0),
      .mem_wdata(wdata0), .mem_rdata(rdata0)
   );

   ahb_lite_sram_slave #(.DEPTH_LOG2(13), .WAIT_STATES(3)) u3 (
      .HCLK(clk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro3),
      .HREADYOUT(hro3), .HRESP(hresp3), .HRDATA(hrdata3),
      .mem_en(en3), .mem_we(we3), .mem_be(be3), .mem_addr(addr3),
      .mem_wdata(wdata3), .mem_rdata(rdata3)
   );

   // Behavioural SRAM for u0: byte-masked write, 1-cycle registered read.
   always @(posedge clk) begin
      if (en0 && we0) begin
         for (int b = 0; b < 8; b++)
            if (be0[b]) mem0[addr0][b*8 +: 8] <= wdata0[b*8 +: 8];
      end
      if (en0 && !we0) rdata0 <= mem0[addr0];
   end

   // Behavioural SRAM for u3, also counting issued writes.
   always @(posedge clk) begin
      if (en3 && we3) begin
         wr_cnt3 <= wr_cnt3 + 1;
         for (int b = 0; b < 8; b++)
            if (be3[b]) mem3[addr3][b*8 +: 8] <= wdata3[b*8 +: 8];
      end
      if (en3 && !we3) rdata3 <= mem3[addr3];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_ph(input logic to3, input logic [31:0] a, input logic w, input logic [2:0] s);
      hsel0  = !to3;
      hsel3  = to3;
      haddr  = a;
      hwrite = w;
      hsize  = s;
      htrans = HTRANS_NONSEQ;
   endtask

   task automatic idle_bus();
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = HTRANS_IDLE;
   endtask

   // Count stalled cycles of u3's current data phase; stops on completion.
   task automatic count_stalls(output int n);
      n = 0;
      while (hro3 !== 1'b1 && n < 20) begin
         n++;
         cyc();
      end
   endtask

   initial begin
      int st;
      int wsave;
      hreset  = 1'b1;
      hready0 = 1'b1;
      hwdata  = 64'h0;
      haddr   = 32'h0;
      hwrite  = 1'b0;
      hsize   = HSIZE_BYTE;
      idle_bus();
      cyc();
      cyc();
      check("rst_hreadyout", {63'h0, hro0}, 64'h1);
      check("rst_hresp",     {63'h0, hresp0}, 64'h0);
      check("rst_hrdata",    hrdata0, 64'h0);
      check("rst_mem_en",    {63'h0, en0}, 64'h0);
      check("rst_mem_we",    {63'h0, we0}, 64'h0);
      check("rst_mem_be",    {56'h0, be0}, 64'h0);
      check("rst3_hreadyout", {63'h0, hro3}, 64'h1);
      hreset = 1'b0;

      // ---- WAIT_STATES=0: dword write then pipelined read of 0x10 ----
      addr_ph(1'b0, 32'h10, 1'b1, HSIZE_DWORD);
      cyc();
      hwdata = 64'h1122334455667788;
      addr_ph(1'b0, 32'h10, 1'b0, HSIZE_DWORD);
      check("wr_mem_en",    {63'h0, en0}, 64'h1);
      check("wr_mem_we",    {63'h0, we0}, 64'h1);
      check("wr_mem_be",    {56'h0, be0}, 64'hFF);
      check("wr_mem_addr",  {51'h0, addr0}, 64'h2);
      check("wr_hreadyout", {63'h0, hro0}, 64'h1);
      check("wr_mem_wdata", wdata0, 64'h1122334455667788);
      cyc();
      idle_bus();
      check("rd_wait_hreadyout", {63'h0, hro0}, 64'h0);
      check("rd_mem_en",  {63'h0, en0}, 64'h1);
      check("rd_mem_we",  {63'h0, we0}, 64'h0);
      cyc();
      check("rd_hrdata",    hrdata0, 64'h1122334455667788);
      check("rd_hresp",     {63'h0, hresp0}, 64'h0);
      check("rd_hreadyout", {63'h0, hro0}, 64'h1);

      // ---- byte write 0xAB at 0x13, then dword read ----
      addr_ph(1'b0, 32'h13, 1'b1, HSIZE_BYTE);
      cyc();
      hwdata = 64'h00000000AB000000;
      addr_ph(1'b0, 32'h10, 1'b0, HSIZE_DWORD);
      check("bwr_mem_be", {56'h0, be0}, 64'h08);
      check("bwr_mem_we", {63'h0, we0}, 64'h1);
      cyc();
      idle_bus();
      cyc();
      check("bwr_readback", hrdata0, 64'h11223344AB667788);

      // ---- errors: misaligned half, misaligned word, out of range ----
      addr_ph(1'b0, 32'h11, 1'b1, HSIZE_HALF);
      cyc();
      idle_bus();
      check("half_err1_hreadyout", {63'h0, hro0}, 64'h0);
      check("half_err1_hresp",     {63'h0, hresp0}, 64'h1);
      check("half_err1_mem_en",    {63'h0, en0}, 64'h0);
      cyc();
      check("half_err2_hreadyout", {63'h0, hro0}, 64'h1);
      check("half_err2_hresp",     {63'h0, hresp0}, 64'h1);
      check("half_err2_mem_en",    {63'h0, en0}, 64'h0);
      addr_ph(1'b0, 32'h16, 1'b0, HSIZE_WORD);
      cyc();
      idle_bus();
      check("word_err1_hreadyout", {63'h0, hro0}, 64'h0);
      check("word_err1_hresp",     {63'h0, hresp0}, 64'h1);
      check("word_err1_mem_en",    {63'h0, en0}, 64'h0);
      cyc();
      check("word_err2_hreadyout", {63'h0, hro0}, 64'h1);
      check("word_err2_hresp",     {63'h0, hresp0}, 64'h1);
      addr_ph(1'b0, 32'h0001_0000, 1'b0, HSIZE_DWORD);
      cyc();
      idle_bus();
      check("range_err1_hresp",  {63'h0, hresp0}, 64'h1);
      check("range_err1_mem_en", {63'h0, en0}, 64'h0);
      cyc();
      check("range_err2_hresp",     {63'h0, hresp0}, 64'h1);
      check("range_err2_hreadyout", {63'h0, hro0}, 64'h1);

      // ---- BUSY, unselected NONSEQ, HREADY low ----
      hsel0  = 1'b1;
      htrans = HTRANS_BUSY;
      cyc();
      cyc();
      check("busy_hreadyout", {63'h0, hro0}, 64'h1);
      check("busy_hresp",     {63'h0, hresp0}, 64'h0);
      check("busy_mem_en",    {63'h0, en0}, 64'h0);
      addr_ph(1'b0, 32'h10, 1'b0, HSIZE_DWORD);
      hsel0 = 1'b0;
      cyc();
      check("nosel_mem_en",    {63'h0, en0}, 64'h0);
      check("nosel_hreadyout", {63'h0, hro0}, 64'h1);
      hsel0   = 1'b1;
      hready0 = 1'b0;
      cyc();
      check("hready_low_mem_en", {63'h0, en0}, 64'h0);
      hready0 = 1'b1;
      idle_bus();

      // ---- reset during RDATA ----
      addr_ph(1'b0, 32'h10, 1'b0, HSIZE_DWORD);
      cyc();
      idle_bus();
      cyc();
      check("pre_rst_hrdata", hrdata0, 64'h11223344AB667788);
      hreset = 1'b1;
      cyc();
      check("rst_rdata_hreadyout", {63'h0, hro0}, 64'h1);
      check("rst_rdata_hresp",     {63'h0, hresp0}, 64'h0);
      check("rst_rdata_hrdata",    hrdata0, 64'h0);
      check("rst_rdata_mem_en",    {63'h0, en0}, 64'h0);
      hreset = 1'b0;
      addr_ph(1'b0, 32'h10, 1'b0, HSIZE_DWORD);
      cyc();
      idle_bus();
      check("post_rst_rd_mem_en", {63'h0, en0}, 64'h1);
      cyc();
      check("post_rst_hrdata", hrdata0, 64'h11223344AB667788);

      // ---- WAIT_STATES=3: reset during WAIT abandons the write ----
      addr_ph(1'b1, 32'h20, 1'b1, HSIZE_DWORD);
      cyc();
      idle_bus();
      hwdata = 64'hDEADDEADDEADDEAD;
      wsave  = wr_cnt3;
      check("ws_wait_hreadyout", {63'h0, hro3}, 64'h0);
      hreset = 1'b1;
      cyc();
      check("rst_wait_hreadyout", {63'h0, hro3}, 64'h1);
      check("rst_wait_hresp",     {63'h0, hresp3}, 64'h0);
      check("rst_wait_hrdata",    hrdata3, 64'h0);
      check("rst_wait_mem_en",    {63'h0, en3}, 64'h0);
      hreset = 1'b0;
      cyc();
      cyc();
      cyc();
      cyc();
      check("rst_wait_no_write", 64'(wr_cnt3), 64'(wsave));

      // ---- back-to-back write, read, write, read with HREADY tied ----
      addr_ph(1'b1, 32'h20, 1'b1, HSIZE_DWORD);
      cyc();
      hwdata = 64'h0123456789ABCDEF;
      addr_ph(1'b1, 32'h20, 1'b0, HSIZE_DWORD);
      count_stalls(st);
      check("ws_wr1_stalls", 64'(st), 64'd3);
      check("ws_wr1_mem_we", {63'h0, we3}, 64'h1);
      cyc();
      addr_ph(1'b1, 32'h28, 1'b1, HSIZE_DWORD);
      count_stalls(st);
      check("ws_rd1_stalls", 64'(st), 64'd4);
      check("ws_rd1_hrdata", hrdata3, 64'h0123456789ABCDEF);
      cyc();
      hwdata = 64'hA5A5_5A5A_F00D_BEEF;
      addr_ph(1'b1, 32'h28, 1'b0, HSIZE_DWORD);
      count_stalls(st);
      check("ws_wr2_stalls", 64'(st), 64'd3);
      cyc();
      idle_bus();
      count_stalls(st);
      check("ws_rd2_stalls", 64'(st), 64'd4);
      check("ws_rd2_hrdata", hrdata3, 64'hA5A5_5A5A_F00D_BEEF);
      check("ws_rd2_hresp",  {63'h0, hresp3}, 64'h0);
      cyc();
      check("ws_end_idle_hrdata", hrdata3, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
